fifo_param: RTL and testbench

- Parametrised synchronous single-clock FIFO; next generation of the team's 8x8 FIFO.
- Adds configurable data width and depth, and uses all DEPTH entries (extra pointer wrap bit).
- Adds a working occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a read-valid strobe.
- Sits between a producer and a consumer, each with its own enable handshake, in the SV verification environment.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 31 +++
 rtl/fifo_param.sv | 99 +++++++++
 tb/tb_fifo_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the parametrised FIFO and its bench.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Pointer width: address bits plus one wrap bit, so all DEPTH entries are usable.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: one write port, one registered read port.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // The array itself carries no reset; only the output register does.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy, thresholds and sticky errors.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_enb,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         rd_enb,
  output logic [WIDTH-1:0]             data_out,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  fifo_err_t     err_q, err_d;
  logic          wr_ok, rd_ok;

  // Handshake: a request is accepted in the cycle it is high and the matching
  // *_ok is true; there is no backpressure signal, rejected requests are simply
  // dropped and recorded in the sticky error flags. A write to a full FIFO is
  // accepted only when a read frees a slot in the same cycle.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_ok = rd_enb & ~empty;
  assign wr_ok = wr_enb & (~full | rd_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + PW'(wr_ok) - PW'(rd_ok);
    rd_valid_d = rd_ok;
    err_d      = err_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    if (clr_err) err_d = '0;
    // New errors are applied after the clear so they win a same-cycle race.
    if (wr_enb & full & ~rd_enb) err_d.overflow  = 1'b1;
    if (rd_enb & empty)          err_d.underflow = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (data_out)
  );

  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: an 8x8 instance and a 16x16 instance for wrap traffic.
module tb_fifo_param;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8x8 instance
  logic       wr_enb, rd_enb, clr_err;
  logic [7:0] data_in, data_out;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0] count;

  fifo_param #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_enb(wr_enb), .data_in(data_in), .rd_enb(rd_enb),
    .data_out(data_out), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  // 16x16 instance
  logic        b_wr_enb, b_rd_enb, b_clr_err;
  logic [15:0] b_data_in, b_data_out;
  logic        b_rd_valid, b_empty, b_full, b_almost_empty, b_almost_full, b_overflow, b_underflow;
  logic [4:0]  b_count;

  fifo_param #(.WIDTH(16), .DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_enb(b_wr_enb), .data_in(b_data_in), .rd_enb(b_rd_enb),
    .data_out(b_data_out), .rd_valid(b_rd_valid), .empty(b_empty), .full(b_full),
    .almost_empty(b_almost_empty), .almost_full(b_almost_full), .count(b_count),
    .overflow(b_overflow), .underflow(b_underflow), .clr_err(b_clr_err)
  );

  logic [15:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fifo_err_t e;
    rst_n = 1'b0;
    wr_enb = 0; rd_enb = 0; clr_err = 0; data_in = '0;
    b_wr_enb = 0; b_rd_enb = 0; b_clr_err = 0; b_data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    e = '{overflow: overflow, underflow: underflow};
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if (e !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", e); end
    total++; if ({rd_valid, almost_empty, almost_full} !== 3'b010) begin
      bad++; $display("FAIL reset_misc got=%b exp=010", {rd_valid, almost_empty, almost_full});
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      wr_enb = 1; data_in = 8'(i);
      tick();
      total++; if (count !== 4'(i)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
      total++; if (almost_full !== (i >= 6)) begin bad++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i >= 6)); end
      total++; if (almost_empty !== (i <= 2)) begin bad++; $display("FAIL fill_ae i=%0d got=%b exp=%b", i, almost_empty, (i <= 2)); end
      total++; if (full !== (i == 8)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i == 8)); end
    end
    data_in = 8'h99;
    tick();
    wr_enb = 0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL ovf_udf got=%b exp=0", underflow); end
  endtask

  task automatic test_drain_underflow();
    rd_enb = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (data_out !== 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, rd_valid); end
      total++; if (count !== 4'(8 - i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 8 - i); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
    tick();
    rd_enb = 0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", underflow); end
    total++; if (data_out !== 8'h08) begin bad++; $display("FAIL udf_data got=%h exp=08", data_out); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL udf_valid got=%b exp=0", rd_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_err = 1;
    tick();
    clr_err = 0;
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL clr_both got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) begin
      wr_enb = 1; data_in = 8'h10 + 8'(i);
      tick();
    end
    rd_enb = 1; data_in = 8'hAA;
    tick();
    wr_enb = 0;
    total++; if (data_out !== 8'h10) begin bad++; $display("FAIL frw_data got=%h exp=10", data_out); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL frw_count got=%0d exp=8", count); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL frw_full got=%b exp=1", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL frw_ovf got=%b exp=0", overflow); end
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] e;
      e = (i == 8) ? 8'hAA : 8'h10 + 8'(i);
      tick();
      total++; if (data_out !== e) begin bad++; $display("FAIL frw_drain i=%0d got=%h exp=%h", i, data_out, e); end
    end
    rd_enb = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL frw_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_rw();
    wr_enb = 1; rd_enb = 1; data_in = 8'h55;
    tick();
    wr_enb = 0; rd_enb = 0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL erw_count got=%0d exp=1", count); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL erw_udf got=%b exp=1", underflow); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL erw_valid got=%b exp=0", rd_valid); end
    total++; if (data_out !== 8'hAA) begin bad++; $display("FAIL erw_hold got=%h exp=aa", data_out); end
    rd_enb = 1;
    tick();
    total++; if (data_out !== 8'h55) begin bad++; $display("FAIL erw_read got=%h exp=55", data_out); end
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL erw_rvalid got=%b exp=1", rd_valid); end
    clr_err = 1;
    tick();
    rd_enb = 0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", underflow); end
    tick();
    clr_err = 0;
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL erw_clr got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      wr_enb = 1; data_in = 8'h21 + 8'(i);
      tick();
    end
    wr_enb = 0; rd_enb = 1;
    tick();
    rd_enb = 0;
    total++; if (data_out !== 8'h21) begin bad++; $display("FAIL mid_pre got=%h exp=21", data_out); end
    rst_n = 1'b0;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_data got=%h exp=00", data_out); end
    total++; if ({empty, full, almost_empty, almost_full, rd_valid} !== 5'b10100) begin
      bad++; $display("FAIL mid_flags got=%b exp=10100", {empty, full, almost_empty, almost_full, rd_valid});
    end
    #4 rst_n = 1'b1;
    rd_enb = 1;
    tick();
    rd_enb = 0;
    total++; if ({underflow, rd_valid} !== 2'b10) begin bad++; $display("FAIL mid_discard got=%b exp=10", {underflow, rd_valid}); end
    clr_err = 1;
    tick();
    clr_err = 0;
  endtask

  task automatic test_wrap16();
    logic [15:0] w;
    int k;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      w = 16'h1234 + 16'(k * 3); k++;
      b_wr_enb = 1; b_data_in = w; exp_q.push_back(w);
      tick();
    end
    total++; if ({b_full, b_count} !== {1'b1, 5'd16}) begin bad++; $display("FAIL w16_full got=%b/%0d exp=1/16", b_full, b_count); end
    b_rd_enb = 1;
    for (int i = 0; i < 24; i++) begin
      w = 16'h1234 + 16'(k * 3); k++;
      b_data_in = w; exp_q.push_back(w);
      w = exp_q.pop_front();
      tick();
      total++; if (b_data_out !== w) begin bad++; $display("FAIL w16_rw i=%0d got=%h exp=%h", i, b_data_out, w); end
      total++; if (b_count !== 5'd16) begin bad++; $display("FAIL w16_rwcnt i=%0d got=%0d exp=16", i, b_count); end
    end
    b_wr_enb = 0;
    for (int i = 0; i < 16; i++) begin
      w = exp_q.pop_front();
      tick();
      total++; if (b_data_out !== w || b_rd_valid !== 1'b1) begin
        bad++; $display("FAIL w16_drain i=%0d got=%h/%b exp=%h/1", i, b_data_out, b_rd_valid, w);
      end
    end
    b_rd_enb = 0;
    total++; if ({b_empty, b_overflow, b_underflow} !== 3'b100) begin
      bad++; $display("FAIL w16_end got=%b exp=100", {b_empty, b_overflow, b_underflow});
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_full_rw();
    test_empty_rw();
    test_reset_mid();
    test_wrap16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
